llsc_monitor: RTL and testbench

- Multi-context load-linked / store-conditional reservation monitor for the MEM stage.
- Successor to the single-bit LLbit register. Holds one reservation (valid bit + address tag + age counter) per hardware context.
- Decides SC success against the reserved address.
- Invalidates reservations on exception flush, on conflicting stores from any context, and on an optional timeout.

---
 rtl/llsc_monitor_pkg.sv | 19 +
 rtl/llsc_monitor_if.sv | 42 ++++
 rtl/llsc_rsv_entry.sv | 91 +++++++++
 rtl/llsc_monitor.sv | 110 +++++++++++
 tb/tb_llsc_monitor.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/llsc_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : llsc_monitor_pkg
// Description : Shared constants for the LL/SC reservation monitor.
//               RstEnable   - level of rst_n that holds the design in reset
//               WriteEnable - asserted level of request strobes
//               LLSC_*_DEF  - default granule and timeout settings
// Revision    : 1.0 - initial multi-context release
// ============================================================================
package llsc_monitor_pkg;

    localparam logic RstEnable         = 1'b0;
    localparam logic WriteEnable       = 1'b1;

    localparam int   LLSC_GRAN_LSB_DEF = 2;
    localparam int   LLSC_TIMEOUT_DEF  = 0;

endpackage
`default_nettype wire

// File: rtl/llsc_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : llsc_monitor_if
// Description : MEM-stage request/response bundle of the LL/SC monitor.
//   master : pipeline side - drives flush, LL, SC and store snoop requests,
//            receives the SC response and the per-context reservation bits.
//   slave  : monitor side - the reverse directions.
// Revision    : 1.0 - initial multi-context release
// ============================================================================
interface llsc_monitor_if #(
    parameter int NUM_CTX = 2,
    parameter int CTX_W   = 1,
    parameter int ADDR_W  = 32
);

    logic [NUM_CTX-1:0] flush;
    logic               ll_valid;
    logic [CTX_W-1:0]   ll_ctx;
    logic [ADDR_W-1:0]  ll_addr;
    logic               sc_valid;
    logic [CTX_W-1:0]   sc_ctx;
    logic [ADDR_W-1:0]  sc_addr;
    logic               st_valid;
    logic [ADDR_W-1:0]  st_addr;
    logic               sc_resp_valid;
    logic               sc_success;
    logic [NUM_CTX-1:0] llbit_o;

    modport master (
        output flush, ll_valid, ll_ctx, ll_addr,
        output sc_valid, sc_ctx, sc_addr, st_valid, st_addr,
        input  sc_resp_valid, sc_success, llbit_o
    );

    modport slave (
        input  flush, ll_valid, ll_ctx, ll_addr,
        input  sc_valid, sc_ctx, sc_addr, st_valid, st_addr,
        output sc_resp_valid, sc_success, llbit_o
    );

endinterface
`default_nettype wire

// File: rtl/llsc_rsv_entry.sv
`default_nettype none
// ============================================================================
// Module      : llsc_rsv_entry
// Description : One context's reservation: valid bit, granule tag and an
//               optional age counter that expires the reservation.
//   clk, rst_n        : clock, asynchronous active-low reset
//   flush             : clear reservation (highest priority)
//   ll_set, ll_tag    : LL to this context - set reservation on ll_tag
//   sc_clr            : SC from this context - clear reservation
//   st_valid, st_tag  : snooped store - clears on tag match
//   rsv_v, rsv_tag    : registered reservation state
// Revision    : 1.0 - initial multi-context release
// ============================================================================
module llsc_rsv_entry
    import llsc_monitor_pkg::*;
#(
    parameter int TAG_W       = 30,
    parameter int TIMEOUT_CYC = 0,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             ll_set,
    input  logic [TAG_W-1:0] ll_tag,
    input  logic             sc_clr,
    input  logic             st_valid,
    input  logic [TAG_W-1:0] st_tag,
    output logic             rsv_v,
    output logic [TAG_W-1:0] rsv_tag
);

    logic st_hit;
    logic expire;
    logic v_next;
    logic set_eff;

    assign st_hit  = (st_valid == WriteEnable) && (st_tag == rsv_tag);
    assign set_eff = ll_set && !flush;

    // flush > LL > (SC | matching store | timeout) > hold
    always_comb begin
        v_next = rsv_v;
        if (flush) begin
            v_next = 1'b0;
        end else if (ll_set) begin
            v_next = 1'b1;
        end else if (sc_clr || st_hit || expire) begin
            v_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == RstEnable) begin
            rsv_v   <= 1'b0;
            rsv_tag <= '0;
        end else begin
            rsv_v <= v_next;
            if (set_eff) begin
                rsv_tag <= ll_tag;
            end
        end
    end

    generate
        if (TIMEOUT_CYC > 0 && CNT_W > 0) begin : g_timeout
            localparam logic [CNT_W-1:0] AGE_LAST = CNT_W'(TIMEOUT_CYC - 1);
            localparam logic [CNT_W-1:0] AGE_SAT  = CNT_W'(TIMEOUT_CYC);

            logic [CNT_W-1:0] rsv_age;

            always_ff @(posedge clk or negedge rst_n) begin
                if (rst_n == RstEnable) begin
                    rsv_age <= '0;
                end else if (set_eff) begin
                    rsv_age <= '0;
                end else if (rsv_v && (rsv_age != AGE_SAT)) begin
                    rsv_age <= rsv_age + 1'b1;
                end
            end

            // Age reaches TIMEOUT_CYC on this edge: drop the reservation so
            // it stays valid for exactly TIMEOUT_CYC cycles after the LL.
            assign expire = rsv_v && (rsv_age == AGE_LAST);
        end else begin : g_no_timeout
            assign expire = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/llsc_monitor.sv
`default_nettype none
// ============================================================================
// Module      : llsc_monitor
// Description : Multi-context load-linked / store-conditional reservation
//               monitor. One reservation per hardware context; SC is judged
//               against pre-edge state and answered one cycle later.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : llsc_monitor_if.slave - flush / LL / SC / store snoop in,
//                sc_resp_valid / sc_success / llbit_o out
// Revision    : 1.0 - initial multi-context release
// ============================================================================
module llsc_monitor
    import llsc_monitor_pkg::*;
#(
    parameter int NUM_CTX     = 2,
    parameter int CTX_W       = 1,
    parameter int ADDR_W      = 32,
    parameter int GRAN_LSB    = LLSC_GRAN_LSB_DEF,
    parameter int TIMEOUT_CYC = LLSC_TIMEOUT_DEF,
    parameter int CNT_W       = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    llsc_monitor_if.slave  bus
);

    localparam int TAG_W = ADDR_W - GRAN_LSB;

    logic [TAG_W-1:0]   ll_tag;
    logic [TAG_W-1:0]   sc_tag;
    logic [TAG_W-1:0]   st_tag;
    logic [NUM_CTX-1:0] ll_sel;
    logic [NUM_CTX-1:0] sc_sel;
    logic [NUM_CTX-1:0] rsv_v;
    logic [TAG_W-1:0]   rsv_tag [NUM_CTX];
    logic               sc_hit;
    logic               resp_valid_q;
    logic               success_q;

    assign ll_tag = bus.ll_addr[ADDR_W-1:GRAN_LSB];
    assign sc_tag = bus.sc_addr[ADDR_W-1:GRAN_LSB];
    assign st_tag = bus.st_addr[ADDR_W-1:GRAN_LSB];

    generate
        if (GRAN_LSB > 0) begin : g_low_bits
            logic unused_low;
            assign unused_low = ^{bus.ll_addr[GRAN_LSB-1:0],
                                  bus.sc_addr[GRAN_LSB-1:0],
                                  bus.st_addr[GRAN_LSB-1:0]};
        end
    endgenerate

    // Context decode. An out-of-range index selects no entry, so the
    // request has no effect and an SC can never find a reservation.
    always_comb begin
        ll_sel = '0;
        sc_sel = '0;
        sc_hit = 1'b0;
        for (int i = 0; i < NUM_CTX; i++) begin
            if ((bus.ll_valid == WriteEnable) && (bus.ll_ctx == CTX_W'(i))) begin
                ll_sel[i] = 1'b1;
            end
            if ((bus.sc_valid == WriteEnable) && (bus.sc_ctx == CTX_W'(i))) begin
                sc_sel[i] = 1'b1;
                if (rsv_v[i] && (rsv_tag[i] == sc_tag)) begin
                    sc_hit = 1'b1;
                end
            end
        end
    end

    generate
        for (genvar i = 0; i < NUM_CTX; i++) begin : g_ctx
            llsc_rsv_entry #(
                .TAG_W       (TAG_W),
                .TIMEOUT_CYC (TIMEOUT_CYC),
                .CNT_W       (CNT_W)
            ) u_entry (
                .clk      (clk),
                .rst_n    (rst_n),
                .flush    (bus.flush[i]),
                .ll_set   (ll_sel[i]),
                .ll_tag   (ll_tag),
                .sc_clr   (sc_sel[i]),
                .st_valid (bus.st_valid),
                .st_tag   (st_tag),
                .rsv_v    (rsv_v[i]),
                .rsv_tag  (rsv_tag[i])
            );
        end
    endgenerate

    // sc_hit already requires sc_valid, so success can't outlive the
    // response strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == RstEnable) begin
            resp_valid_q <= 1'b0;
            success_q    <= 1'b0;
        end else begin
            resp_valid_q <= bus.sc_valid;
            success_q    <= sc_hit;
        end
    end

    assign bus.sc_resp_valid = resp_valid_q;
    assign bus.sc_success    = success_q;
    assign bus.llbit_o       = rsv_v;

endmodule
`default_nettype wire

// File: tb/tb_llsc_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_llsc_monitor
// Description : Self-checking bench for llsc_monitor. Two instances share one
//               stimulus stream: A (4 contexts, 3-bit ctx, timeout 4) and
//               B (defaults: 2 contexts, no timeout). A reference model holds
//               per-context reservations and the LL edge timestamp.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_llsc_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  flush;
    logic        llv;
    logic [2:0]  llc;
    logic [31:0] lla;
    logic        scv;
    logic [2:0]  scc;
    logic [31:0] sca;
    logic        stv;
    logic [31:0] sta;

    always #5 clk = ~clk;

    llsc_monitor_if #(.NUM_CTX(4), .CTX_W(3), .ADDR_W(32)) ifa ();
    llsc_monitor_if #(.NUM_CTX(2), .CTX_W(1), .ADDR_W(32)) ifb ();

    assign ifa.flush    = flush;
    assign ifa.ll_valid = llv;
    assign ifa.ll_ctx   = llc;
    assign ifa.ll_addr  = lla;
    assign ifa.sc_valid = scv;
    assign ifa.sc_ctx   = scc;
    assign ifa.sc_addr  = sca;
    assign ifa.st_valid = stv;
    assign ifa.st_addr  = sta;

    assign ifb.flush    = flush[1:0];
    assign ifb.ll_valid = llv;
    assign ifb.ll_ctx   = llc[0];
    assign ifb.ll_addr  = lla;
    assign ifb.sc_valid = scv;
    assign ifb.sc_ctx   = scc[0];
    assign ifb.sc_addr  = sca;
    assign ifb.st_valid = stv;
    assign ifb.st_addr  = sta;

    llsc_monitor #(
        .NUM_CTX     (4),
        .CTX_W       (3),
        .ADDR_W      (32),
        .GRAN_LSB    (2),
        .TIMEOUT_CYC (4),
        .CNT_W       (16)
    ) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    llsc_monitor dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    // ---------------- checking ----------------
    int    checks = 0;
    int    errors = 0;
    string phase  = "init";

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s/%s: got %0h expected %0h", phase, tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_v   [2][8];
    logic [29:0] m_tag [2][8];
    int          m_llt [2][8];
    bit          exp_rv [2];
    bit          exp_ok [2];
    int          n_edge = 0;

    function automatic int num_of(input int d);
        return (d == 0) ? 4 : 2;
    endfunction

    function automatic int to_of(input int d);
        return (d == 0) ? 4 : 0;
    endfunction

    function automatic logic [31:0] mbits(input int d);
        logic [31:0] r = '0;
        for (int i = 0; i < 8; i++) r[i] = m_v[d][i];
        return r;
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            exp_rv[d] = 1'b0;
            exp_ok[d] = 1'b0;
            for (int i = 0; i < 8; i++) begin
                m_v[d][i]   = 1'b0;
                m_tag[d][i] = '0;
                m_llt[d][i] = 0;
            end
        end
    endtask

    // Applies the current inputs as one clock edge to both model instances.
    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            int          nc = num_of(d);
            int          to = to_of(d);
            int          f  = (d == 0) ? int'(flush) : int'(flush[1:0]);
            int          lc = (d == 0) ? int'(llc) : int'(llc[0]);
            int          sc = (d == 0) ? int'(scc) : int'(scc[0]);
            bit          nv [8];
            logic [29:0] nt [8];
            int          nl [8];
            exp_rv[d] = scv;
            exp_ok[d] = scv && (sc < nc) && m_v[d][sc] && (m_tag[d][sc] == sca[31:2]);
            for (int i = 0; i < 8; i++) begin
                nv[i] = m_v[d][i];
                nt[i] = m_tag[d][i];
                nl[i] = m_llt[d][i];
            end
            for (int i = 0; i < nc; i++) begin
                if (f[i]) begin
                    nv[i] = 1'b0;
                end else if (llv && lc == i) begin
                    nv[i] = 1'b1;
                    nt[i] = lla[31:2];
                    nl[i] = n_edge;
                end else if ((scv && sc == i) ||
                             (stv && m_tag[d][i] == sta[31:2]) ||
                             (to > 0 && m_v[d][i] && (n_edge - m_llt[d][i]) >= to)) begin
                    nv[i] = 1'b0;
                end
            end
            for (int i = 0; i < 8; i++) begin
                m_v[d][i]   = nv[i];
                m_tag[d][i] = nt[i];
                m_llt[d][i] = nl[i];
            end
        end
        n_edge++;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        flush = '0;
        llv   = 1'b0;
        scv   = 1'b0;
        stv   = 1'b0;
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        check("a_resp",  ifa.sc_resp_valid, exp_rv[0]);
        check("a_ok",    ifa.sc_success,    exp_ok[0]);
        check("a_llbit", ifa.llbit_o,       mbits(0));
        check("b_resp",  ifb.sc_resp_valid, exp_rv[1]);
        check("b_ok",    ifb.sc_success,    exp_ok[1]);
        check("b_llbit", ifb.llbit_o,       mbits(1));
    endtask

    task automatic do_ll(input int c, input logic [31:0] a);
        llv = 1'b1; llc = 3'(c); lla = a;
    endtask

    task automatic do_sc(input int c, input logic [31:0] a);
        scv = 1'b1; scc = 3'(c); sca = a;
    endtask

    task automatic mid_reset();
        rst_n = 1'b0;
        #1;
        check("async_llbit_a", ifa.llbit_o, 0);
        check("async_llbit_b", ifb.llbit_o, 0);
        check("async_resp_a",  ifa.sc_resp_valid, 0);
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] base;
        case ($urandom_range(0, 3))
            0:       base = 32'h0000_0100;
            1:       base = 32'h0000_0104;
            2:       base = 32'h0000_0108;
            default: base = 32'h8000_0100;
        endcase
        return base + 32'($urandom_range(0, 3));
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        rst_n = 1'b0;
        llc = '0; scc = '0; lla = '0; sca = '0; sta = '0;
        idle();
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        phase = "reset";
        check("resp_a",  ifa.sc_resp_valid, 0);
        check("ok_a",    ifa.sc_success,    0);
        check("llbit_a", ifa.llbit_o,       0);
        check("llbit_b", ifb.llbit_o,       0);
        rst_n = 1'b1;

        phase = "rst_mid";
        idle(); do_ll(0, 32'h1000); cycle();
        check("llbit_set", ifa.llbit_o, 1);
        idle(); mid_reset();
        do_sc(0, 32'h1000); cycle();
        check("sc_resp", ifa.sc_resp_valid, 1);
        check("sc_ok",   ifa.sc_success,    0);

        phase = "basic";
        idle(); do_ll(1, 32'h2004); cycle();
        idle(); cycle();
        do_sc(1, 32'h2006); cycle();
        check("sc_ok",  ifa.sc_success, 1);
        check("llbit1", ifa.llbit_o[1], 0);
        cycle();
        check("sc2_ok", ifa.sc_success, 0);
        idle(); cycle();
        check("resp_one_cycle", ifa.sc_resp_valid, 0);

        phase = "xstore";
        idle(); do_ll(0, 32'h3000); cycle();
        do_ll(1, 32'h3000); cycle();
        check("both_set", ifa.llbit_o[1:0], 2'b11);
        idle(); stv = 1'b1; sta = 32'h3000; cycle();
        check("both_clr", ifa.llbit_o[1:0], 2'b00);
        do_ll(0, 32'h3000); cycle();
        check("ll_wins", ifa.llbit_o[0], 1);

        phase = "flush";
        idle(); do_ll(0, 32'h4000); cycle();
        idle(); flush = 4'b0001; cycle();
        check("flushed", ifa.llbit_o[0], 0);
        idle(); do_sc(0, 32'h4000); cycle();
        check("sc_ok", ifa.sc_success, 0);
        idle(); do_ll(0, 32'h4000); cycle();
        idle(); do_sc(0, 32'h4010); cycle();
        check("mis_ok",    ifa.sc_success, 0);
        check("mis_llbit", ifa.llbit_o[0], 0);

        phase = "timeout";
        idle(); do_ll(0, 32'h5000); cycle();
        check("t1", ifa.llbit_o[0], 1);
        idle();
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("hold", ifa.llbit_o[0], 1);
        end
        do_sc(0, 32'h5000); cycle();
        check("sc_t4_ok", ifa.sc_success, 1);
        idle(); do_ll(0, 32'h5000); cycle();
        idle();
        for (int k = 0; k < 4; k++) cycle();
        check("expired", ifa.llbit_o[0], 0);
        do_sc(0, 32'h5000); cycle();
        check("sc_t5_ok", ifa.sc_success, 0);
        check("sc_t5_b_ok", ifb.sc_success, 1);

        phase = "simul";
        idle(); do_ll(2, 32'h6000); cycle();
        do_ll(2, 32'h6100); do_sc(2, 32'h6000); cycle();
        check("sc_ok",  ifa.sc_success, 1);
        check("llbit2", ifa.llbit_o[2], 1);
        idle(); do_sc(2, 32'h6100); cycle();
        check("new_tag_ok", ifa.sc_success, 1);
        idle(); do_ll(3, 32'h7000); cycle();
        idle(); do_sc(5, 32'h7000); cycle();
        check("oor_resp",  ifa.sc_resp_valid, 1);
        check("oor_ok",    ifa.sc_success,    0);
        check("oor_llbit", ifa.llbit_o,       4'b1000);

        phase = "random";
        for (int n = 0; n < 3000; n++) begin
            idle();
            for (int b = 0; b < 4; b++) flush[b] = ($urandom_range(0, 15) == 0);
            llv = ($urandom_range(0, 9) < 3);
            llc = 3'($urandom_range(0, 7));
            lla = rand_addr();
            scv = ($urandom_range(0, 9) < 3);
            scc = 3'($urandom_range(0, 7));
            sca = rand_addr();
            stv = ($urandom_range(0, 9) < 2);
            sta = rand_addr();
            cycle();
        end

        idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
